checkpoint_controller: RTL and testbench

Allocates, tracks and retires register-file checkpoints for speculative branch execution, and sequences rollback on misprediction. Sits between hazard control and the register file. Each predicted branch gets a tagged snapshot of all 32 architectural registers. Correct resolution frees the checkpoint; a misprediction discards that checkpoint and every younger one, then drives the saved register image back to the register file under a valid/ack handshake.

---
 rtl/mips_core_pkg.sv | 15 +
 rtl/checkpoint_controller_if.sv | 31 +++
 rtl/checkpoint_controller_store.sv | 26 ++
 rtl/checkpoint_controller.sv | 114 +++++++++++
 tb/tb_checkpoint_controller.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: data width, register-file image and checkpoint FSM states.
package mips_core_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [0:0] {
    SC_IDLE,
    SC_RESTORE
  } ckpt_state_e;

  // Element i is architectural register i.
  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regfile_image_t;

endpackage

// File: rtl/checkpoint_controller_if.sv
// Hazard-control / register-file side signals of the checkpoint controller.
interface checkpoint_controller_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned TAG_W = $clog2(DEPTH);

  mips_core_pkg::regfile_image_t regs_in;
  logic                          branch_valid;
  logic                          branch_ready;
  logic [TAG_W-1:0]              branch_tag;
  logic                          resolve_valid;
  logic [TAG_W-1:0]              resolve_tag;
  logic                          resolve_mispredict;
  logic                          restore_valid;
  mips_core_pkg::regfile_image_t restore_regs;
  logic                          restore_ack;
  logic                          flush;
  logic [TAG_W:0]                count;
  logic                          error;

  modport master (
    output regs_in, branch_valid, resolve_valid, resolve_tag, resolve_mispredict, restore_ack,
    input  branch_ready, branch_tag, restore_valid, restore_regs, flush, count, error
  );

  modport slave (
    input  regs_in, branch_valid, resolve_valid, resolve_tag, resolve_mispredict, restore_ack,
    output branch_ready, branch_tag, restore_valid, restore_regs, flush, count, error
  );

endinterface

// File: rtl/checkpoint_controller_store.sv
// Checkpoint image storage: one synchronous write port, one combinational read port.
module checkpoint_store
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  regfile_image_t i_wdata,
  input  logic [AW-1:0]  i_raddr,
  output regfile_image_t o_rdata
);

  regfile_image_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/checkpoint_controller.sv
// Allocates, retires and rolls back register-file checkpoints for speculative branches.
module checkpoint_controller
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  checkpoint_controller_if.slave bus
);

  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = TAG_W + 1;

  ckpt_state_e      r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic             r_flush;
  logic             r_restore_valid;
  logic             r_error;
  regfile_image_t   r_restore_regs;

  logic [PTR_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic [TAG_W-1:0] w_offset;
  logic             w_in_flight;
  logic             w_idle;
  logic             w_alloc;
  logic             w_ok_resolve;
  logic             w_mp_resolve;
  logic             w_bad_resolve;
  regfile_image_t   w_rdata;

  assign w_count  = r_tail - r_head;
  assign w_full   = (w_count == PTR_W'(DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_idle   = (r_state == SC_IDLE);

  // Age of resolve_tag relative to head; in flight when younger than tail.
  assign w_offset    = bus.resolve_tag - r_head[TAG_W-1:0];
  assign w_in_flight = ({1'b0, w_offset} < w_count);

  assign w_ok_resolve  = bus.resolve_valid && !bus.resolve_mispredict && w_idle && !w_empty &&
                         (bus.resolve_tag == r_head[TAG_W-1:0]);
  assign w_mp_resolve  = bus.resolve_valid && bus.resolve_mispredict && w_idle && w_in_flight;
  assign w_bad_resolve = bus.resolve_valid && !w_ok_resolve && !w_mp_resolve;

  assign bus.branch_ready = w_idle && !w_full && !(bus.resolve_valid && bus.resolve_mispredict);
  assign w_alloc          = bus.branch_valid && bus.branch_ready;

  checkpoint_store #(
    .DEPTH (DEPTH),
    .AW    (TAG_W)
  ) u_store (
    .i_clk   (i_clk),
    .i_we    (w_alloc),
    .i_waddr (r_tail[TAG_W-1:0]),
    .i_wdata (bus.regs_in),
    .i_raddr (bus.resolve_tag),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= SC_IDLE;
      r_head          <= '0;
      r_tail          <= '0;
      r_flush         <= 1'b0;
      r_restore_valid <= 1'b0;
      r_restore_regs  <= '0;
      r_error         <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      if (w_bad_resolve) begin
        r_error <= 1'b1;
      end
      unique case (r_state)
        SC_IDLE: begin
          if (w_mp_resolve) begin
            // Drop the mispredicted slot and everything younger.
            r_tail          <= r_head + PTR_W'(w_offset);
            r_restore_regs  <= w_rdata;
            r_restore_valid <= 1'b1;
            r_flush         <= 1'b1;
            r_state         <= SC_RESTORE;
          end else begin
            if (w_alloc) begin
              r_tail <= r_tail + PTR_W'(1);
            end
            if (w_ok_resolve) begin
              r_head <= r_head + PTR_W'(1);
            end
          end
        end
        SC_RESTORE: begin
          if (bus.restore_ack) begin
            r_restore_valid <= 1'b0;
            r_state         <= SC_IDLE;
          end
        end
        default: r_state <= SC_IDLE;
      endcase
    end
  end

  assign bus.branch_tag    = r_tail[TAG_W-1:0];
  assign bus.restore_valid = r_restore_valid;
  assign bus.restore_regs  = r_restore_regs;
  assign bus.flush         = r_flush;
  assign bus.count         = w_count;
  assign bus.error         = r_error;

endmodule

// File: tb/tb_checkpoint_controller.sv
// Self-checking bench: directed stimulus with a scoreboard of expected restore images.
module tb_checkpoint_controller;
  import mips_core_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  regfile_image_t exp_q[$];

  always #5 clk = ~clk;

  checkpoint_controller_if #(.DEPTH(DEPTH)) bus ();

  checkpoint_controller #(.DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic regfile_image_t mk_img(input int k);
    regfile_image_t img;
    for (int i = 0; i < 32; i++) begin
      img[i] = DATA_WIDTH'(32'hA0 + k + (i << 8));
    end
    return img;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.branch_valid       = 1'b0;
    bus.resolve_valid      = 1'b0;
    bus.resolve_tag        = '0;
    bus.resolve_mispredict = 1'b0;
    bus.restore_ack        = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input int k, input int exp_tag);
    bus.branch_valid = 1'b1;
    bus.regs_in      = mk_img(k);
    #1;
    check("alloc_ready", bus.branch_ready, 1);
    check("alloc_tag", bus.branch_tag, exp_tag);
    tick();
    bus.branch_valid = 1'b0;
  endtask

  // One-cycle resolve; leaves the bench one cycle later with inputs cleared.
  task automatic resolve(input int tag, input logic mp);
    bus.resolve_valid      = 1'b1;
    bus.resolve_tag        = 2'(tag);
    bus.resolve_mispredict = mp;
    #1;
    if (mp) check("mp_ready_low", bus.branch_ready, 0);
    tick();
    bus.resolve_valid      = 1'b0;
    bus.resolve_mispredict = 1'b0;
  endtask

  task automatic await_restore();
    regfile_image_t e;
    int c = 0;
    while (!bus.restore_valid && c < 8) begin
      tick();
      c++;
    end
    check("restore_valid", bus.restore_valid, 1);
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("restore_r0", bus.restore_regs[0], e[0]);
      check("restore_r9", bus.restore_regs[9], e[9]);
      check("restore_r31", bus.restore_regs[31], e[31]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bus.regs_in = '0;
    do_reset();

    // Reset values
    check("rst_ready", bus.branch_ready, 1);
    check("rst_tag", bus.branch_tag, 0);
    check("rst_rvalid", bus.restore_valid, 0);
    check("rst_rregs", bus.restore_regs[0], 0);
    check("rst_flush", bus.flush, 0);
    check("rst_count", bus.count, 0);
    check("rst_error", bus.error, 0);

    // Fill the buffer
    for (int k = 0; k < 4; k++) alloc(k, k);
    check("full_count", bus.count, 4);
    check("full_ready", bus.branch_ready, 0);

    // Full: retire tag 0 while allocation is attempted
    bus.branch_valid  = 1'b1;
    bus.regs_in       = mk_img(4);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = 2'd0;
    #1;
    check("full_alloc_refused", bus.branch_ready, 0);
    tick();
    bus.resolve_valid = 1'b0;
    #1;
    check("wrap_ready", bus.branch_ready, 1);
    check("wrap_tag", bus.branch_tag, 0);
    tick();
    bus.branch_valid = 1'b0;
    check("wrap_count", bus.count, 4);

    // Mispredict youngest slot (tag 0, wrapped); keeps tags 1..3
    exp_q.push_back(mk_img(4));
    resolve(0, 1'b1);
    check("wrap_mp_flush", bus.flush, 1);
    check("wrap_mp_count", bus.count, 3);
    await_restore();
    bus.restore_ack = 1'b1;
    tick();
    bus.restore_ack = 1'b0;
    check("wrap_mp_flush_off", bus.flush, 0);
    check("wrap_mp_rvalid_off", bus.restore_valid, 0);
    check("wrap_mp_tag", bus.branch_tag, 0);

    // Mispredict tag 1 with ack held off
    do_reset();
    for (int k = 0; k < 4; k++) alloc(10 + k, k);
    exp_q.push_back(mk_img(11));
    resolve(1, 1'b1);
    check("mp_flush_n1", bus.flush, 1);
    check("mp_count", bus.count, 1);
    await_restore();
    tick();
    check("mp_flush_n2", bus.flush, 0);
    check("mp_hold_valid_n2", bus.restore_valid, 1);
    check("mp_hold_ready_n2", bus.branch_ready, 0);
    tick();
    check("mp_hold_valid_n3", bus.restore_valid, 1);
    check("mp_hold_ready_n3", bus.branch_ready, 0);
    check("mp_hold_regs", bus.restore_regs[5], 32'hA0 + 11 + (5 << 8));
    tick();
    bus.restore_ack = 1'b1;
    #1;
    check("mp_valid_at_ack", bus.restore_valid, 1);
    tick();
    bus.restore_ack = 1'b0;
    #1;
    check("mp_valid_after_ack", bus.restore_valid, 0);
    check("mp_ready_after_ack", bus.branch_ready, 1);
    alloc(14, 1);
    check("mp_realloc_count", bus.count, 2);

    // Illegal resolves
    check("err_clear", bus.error, 0);
    resolve(2, 1'b0);
    check("err_bad_tag", bus.error, 1);
    check("err_count_kept", bus.count, 2);
    tick();
    tick();
    tick();
    check("err_sticky", bus.error, 1);
    resolve(0, 1'b0);
    resolve(1, 1'b0);
    check("err_drain_count", bus.count, 0);
    resolve(0, 1'b1);
    check("empty_mp_flush", bus.flush, 0);
    check("empty_mp_rvalid", bus.restore_valid, 0);
    do_reset();
    check("err_rst", bus.error, 0);
    resolve(3, 1'b1);
    check("empty_mp_error", bus.error, 1);
    check("empty_mp_flush2", bus.flush, 0);
    check("empty_mp_count", bus.count, 0);

    // Reset during restore, resolve in restore is illegal
    do_reset();
    alloc(20, 0);
    alloc(21, 1);
    exp_q.push_back(mk_img(20));
    resolve(0, 1'b1);
    await_restore();
    check("rr_count", bus.count, 0);
    resolve(0, 1'b0);
    check("rr_resolve_err", bus.error, 1);
    check("rr_still_valid", bus.restore_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_valid", bus.restore_valid, 0);
    check("rr_count0", bus.count, 0);
    check("rr_ready", bus.branch_ready, 1);
    check("rr_error", bus.error, 0);
    bus.restore_ack = 1'b1;
    tick();
    bus.restore_ack = 1'b0;
    check("idle_ack_valid", bus.restore_valid, 0);
    check("idle_ack_count", bus.count, 0);
    check("idle_ack_error", bus.error, 0);

    // Back-to-back allocate + correct resolve
    do_reset();
    alloc(30, 0);
    for (int i = 0; i < 20; i++) begin
      bus.branch_valid       = 1'b1;
      bus.regs_in            = mk_img(31 + i);
      bus.resolve_valid      = 1'b1;
      bus.resolve_tag        = 2'(i % 4);
      bus.resolve_mispredict = 1'b0;
      #1;
      check("b2b_ready", bus.branch_ready, 1);
      check("b2b_tag", bus.branch_tag, (i + 1) % 4);
      tick();
      check("b2b_count", bus.count, 1);
      check("b2b_error", bus.error, 0);
    end
    clear_in();
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
